// File: rtl/serial_byte_rx.sv
// serial_byte_rx
// Receives one asynchronous-style serial frame at a time and presents the
// byte on a valid/ready handshake. Frame: start bit (0), 8 data bits LSB
// first, optional even-parity bit, stop bit (1). The line is sampled only
// on clk edges where bit_en=1, so bit timing is set entirely by the strobe.
//
// Optional feature: define SERIAL_BYTE_RX_PARITY_EN to add the parity bit
// slot (PAR state) and the par_err output.
//
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   asynchronous active-high reset
//   bit_en    in   one-clk sample strobe per bit period
//   sin       in   serial line, idles high
//   rdy       in   consumer ready; transfer when valid & rdy on a clk edge
//   q         out  received byte, stable while valid=1
//   valid     out  q holds an unconsumed byte
//   busy      out  frame in progress
//   frame_err out  one-clk pulse: stop bit sampled as 0
//   ovr       out  one-clk pulse: good byte dropped because q was still full
//   par_err   out  (PARITY_EN only) one-clk pulse: parity mismatch, byte dropped
module serial_byte_rx (
    input  logic       clk,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       sin,
    input  logic       rdy,
    output logic [7:0] q,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       ovr
`ifdef SERIAL_BYTE_RX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
`ifdef SERIAL_BYTE_RX_PARITY_EN
        ST_PAR  = 2'd2,
`endif
        ST_STOP = 2'd3
    } state_t;

    state_t     state_r;
    logic [2:0] cnt_r;
    logic [7:0] shift_r;

`ifdef SERIAL_BYTE_RX_PARITY_EN
    logic       par_bad_r;

    // Even parity over data plus parity bit: any odd count of ones is a failure.
    function automatic logic parity_fail(input logic [8:0] bits);
        return ^bits;
    endfunction
`endif

    // Receive FSM, shift register, output handshake and error pulses.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            shift_r   <= 8'h00;
            q         <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
            par_bad_r <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            frame_err <= 1'b0;
            ovr       <= 1'b0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
            // Consumer transfer; a byte completing on this same edge overrides below.
            if (valid && rdy) begin
                valid <= 1'b0;
            end

            if (bit_en) begin
                case (state_r)
                    ST_IDLE: begin
                        // A single low sample is taken as the start bit.
                        if (!sin) begin
                            state_r <= ST_DATA;
                            cnt_r   <= 3'd0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        // LSB arrives first, so shifting right leaves it in bit 0.
                        shift_r <= {sin, shift_r[7:1]};
                        cnt_r   <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
`ifdef SERIAL_BYTE_RX_PARITY_EN
                            state_r <= ST_PAR;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end
`ifdef SERIAL_BYTE_RX_PARITY_EN
                    ST_PAR: begin
                        // Verdict is held until the stop bit decides the frame's fate.
                        par_bad_r <= parity_fail({sin, shift_r});
                        state_r   <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        if (!sin) begin
                            frame_err <= 1'b1;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                        end else if (par_bad_r) begin
                            par_err <= 1'b1;
`endif
                        end else if (!valid || rdy) begin
                            q     <= shift_r;
                            valid <= 1'b1;
                        end else begin
                            // Old byte still unconsumed: keep it, drop the new one.
                            ovr <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench for serial_byte_rx: frame-level reference model,
// per-cycle comparison on the falling edge, directed scenarios plus
// randomized frames, bit periods and consumer readiness.
module tb_serial_byte_rx;

    localparam int K_NONE  = 0;
    localparam int K_IDLE  = 1;
    localparam int K_START = 2;
    localparam int K_DATA  = 3;
    localparam int K_PAR   = 4;
    localparam int K_STOP  = 5;

    logic       clk;
    logic       clr;
    logic       bit_en;
    logic       sin;
    logic       rdy;
    logic [7:0] q;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       ovr;
`ifdef SERIAL_BYTE_RX_PARITY_EN
    logic       par_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state (what the outputs must be after the latest edge)
    logic [7:0] m_q     = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_pe    = 1'b0;

    // Frame currently on the line
    logic [7:0] cur_byte   = 8'h00;
    logic       cur_stop   = 1'b1;
    logic       cur_par_ok = 1'b1;

    serial_byte_rx dut (
        .clk       (clk),
        .clr       (clr),
        .bit_en    (bit_en),
        .sin       (sin),
        .rdy       (rdy),
        .q         (q),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .ovr       (ovr)
`ifdef SERIAL_BYTE_RX_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 8'h00; m_valid = 1'b0; m_busy = 1'b0;
        m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
    endtask

    // Frame-level rules applied at one clock edge.
    task automatic model_edge(input int kind, input logic r);
        logic old_valid;
        old_valid = m_valid;
        m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
        if (old_valid && r) m_valid = 1'b0;
        if (kind == K_START) m_busy = 1'b1;
        if (kind == K_STOP) begin
            m_busy = 1'b0;
            if (!cur_stop) m_fe = 1'b1;
            else if (!cur_par_ok) m_pe = 1'b1;
            else if (!old_valid || r) begin
                m_q = cur_byte;
                m_valid = 1'b1;
            end else m_ovr = 1'b1;
        end
    endtask

    // One clock: drive inputs, take the edge, update the model just after it.
    task automatic tick(input logic be, input logic s, input int kind, input int rmode);
        logic r;
        r = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        bit_en = be; sin = s; rdy = r;
        @(posedge clk);
        #1;
        model_edge(kind, r);
    endtask

    // One bit period of p clocks; the strobe lands on the last clock.
    task automatic send_bit(input logic b, input int kind, input int p, input int rmode, input int be_rmode);
        for (int i = 0; i < p - 1; i++) tick(1'b0, b, K_NONE, rmode);
        tick(1'b1, b, kind, be_rmode);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input logic par_good,
                              input int p, input int rmode, input int stop_rmode);
`ifdef SERIAL_BYTE_RX_PARITY_EN
        logic pbit;
`endif
        cur_byte = b; cur_stop = stopv; cur_par_ok = par_good;
        send_bit(1'b0, K_START, p, rmode, rmode);
        for (int i = 0; i < 8; i++) send_bit(b[i], K_DATA, p, rmode, rmode);
`ifdef SERIAL_BYTE_RX_PARITY_EN
        // Even parity: bit makes the total number of ones even when good.
        pbit = (($countones(b) % 2) == 1) ? par_good : !par_good;
        send_bit(pbit, K_PAR, p, rmode, rmode);
`endif
        send_bit(stopv, K_STOP, p, rmode, stop_rmode);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("q", {24'd0, q}, {24'd0, m_q});
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
        check("ovr", {31'd0, ovr}, {31'd0, m_ovr});
        check("fe_ovr_exclusive", {31'd0, frame_err & ovr}, 32'd0);
`ifdef SERIAL_BYTE_RX_PARITY_EN
        check("par_err", {31'd0, par_err}, {31'd0, m_pe});
`endif
    end

    initial begin
        clr = 1'b1; bit_en = 1'b0; sin = 1'b1; rdy = 1'b0;
        #2;
        check("reset_q", {24'd0, q}, 32'h00);
        check("reset_flags", {28'd0, valid, busy, frame_err, ovr}, 32'd0);
        @(posedge clk); @(posedge clk);
        #1 clr = 1'b0;

        // Byte A5, strobe every 4 clocks, consumer always ready
        send_bit(1'b1, K_IDLE, 4, 1, 1);
        send_frame(8'hA5, 1'b1, 1'b1, 4, 1, 1);
        check("a5_q", {24'd0, q}, 32'hA5);
        check("a5_valid", {31'd0, valid}, 32'd1);
        check("a5_busy_low", {31'd0, busy}, 32'd0);
        tick(1'b0, 1'b1, K_NONE, 1);
        check("a5_valid_one_cycle", {31'd0, valid}, 32'd0);

        // Byte 3C with a bad stop bit
        send_frame(8'h3C, 1'b0, 1'b1, 2, 1, 1);
        check("3c_frame_err", {31'd0, frame_err}, 32'd1);
        check("3c_q_kept", {24'd0, q}, 32'hA5);
        check("3c_valid_kept", {31'd0, valid}, 32'd0);
        tick(1'b0, 1'b1, K_NONE, 1);
        check("3c_pulse_one_clk", {30'd0, frame_err, busy}, 32'd0);

        // Overrun: 11 then 22 with consumer stalled
        send_frame(8'h11, 1'b1, 1'b1, 1, 0, 0);
        send_frame(8'h22, 1'b1, 1'b1, 1, 0, 0);
        check("ovr_pulse", {31'd0, ovr}, 32'd1);
        check("ovr_q_held", {24'd0, q}, 32'h11);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        tick(1'b0, 1'b1, K_NONE, 1);
        check("ovr_valid_clear", {30'd0, valid, ovr}, 32'd0);

        // Byte completes on the same edge as a transfer
        send_frame(8'h5A, 1'b1, 1'b1, 1, 0, 0);
        send_frame(8'h96, 1'b1, 1'b1, 1, 0, 1);
        check("same_edge_q", {24'd0, q}, 32'h96);
        check("same_edge_valid_ovr", {30'd0, valid, ovr}, 32'd2);
        tick(1'b0, 1'b1, K_NONE, 1);

        // Reset after the 4th data bit, then a clean FF frame
        cur_byte = 8'hFF; cur_stop = 1'b1; cur_par_ok = 1'b1;
        send_bit(1'b0, K_START, 1, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, K_DATA, 1, 0, 0);
        bit_en = 1'b0;
        #2 clr = 1'b1;
        model_reset();
        #1;
        check("clr_mid_q", {24'd0, q}, 32'h00);
        check("clr_mid_flags", {28'd0, valid, busy, frame_err, ovr}, 32'd0);
        @(posedge clk); @(posedge clk);
        #1 clr = 1'b0;
        send_bit(1'b1, K_IDLE, 1, 0, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 3, 0, 0);
        check("after_clr_ff", {23'd0, valid, q}, 32'h1FF);
        tick(1'b0, 1'b1, K_NONE, 1);

`ifdef SERIAL_BYTE_RX_PARITY_EN
        // 07 with parity bit 1 is good; with parity bit 0 it is rejected
        send_frame(8'h07, 1'b1, 1'b1, 2, 0, 0);
        check("par_good_q", {23'd0, valid, q}, 32'h107);
        tick(1'b0, 1'b1, K_NONE, 1);
        send_frame(8'h07, 1'b1, 1'b0, 2, 0, 0);
        check("par_bad_pulse", {31'd0, par_err}, 32'd1);
        check("par_bad_valid", {31'd0, valid}, 32'd0);
        tick(1'b0, 1'b1, K_NONE, 1);
`endif

        // Randomized frames, gaps, bit periods and readiness
        for (int f = 0; f < 40; f++) begin
            automatic int idle_n = $urandom_range(0, 3);
            automatic int p = $urandom_range(1, 4);
            automatic int rm = $urandom_range(0, 2);
            automatic logic [7:0] b = 8'($urandom_range(0, 255));
            automatic logic stopv = ($urandom_range(0, 7) != 0);
`ifdef SERIAL_BYTE_RX_PARITY_EN
            automatic logic pg = ($urandom_range(0, 7) != 0);
`else
            automatic logic pg = 1'b1;
`endif
            for (int k = 0; k < idle_n; k++) send_bit(1'b1, K_IDLE, p, rm, rm);
            send_frame(b, stopv, pg, p, rm, rm);
        end
        tick(1'b0, 1'b1, K_NONE, 1);
        tick(1'b0, 1'b1, K_NONE, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
